// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state encoding,
// EX operand-select codes and register-index width.
package hazard_ctrl_pkg;

  localparam int REG_W = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL2 = 2'd1,
    ST_STALL1 = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_SUM = 2'b01;
  localparam logic [1:0] FWD_EXT = 2'b10;

  // EX/WB source chosen by what the producer will write back.
  function automatic logic [1:0] fwd_src(input logic se_to_reg);
    if (se_to_reg) begin
      fwd_src = FWD_EXT;
    end else begin
      fwd_src = FWD_SUM;
    end
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;

  // Count register: sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_r <= ZERO;
    end else if (inc && (count_r != ONES)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flush, optional EX/WB
// forwarding selected by defining HAZARD_FORWARDING_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_WriteReg,
  input  logic             ex_SEtoReg,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             wb_WriteReg,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             branch_taken,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

`ifdef HAZARD_FORWARDING_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  state_e     state_r;
  logic [1:0] fwd_a_r;
  logic [1:0] fwd_b_r;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;
  logic       ex_a_s;
  logic       ex_b_s;
  logic       hit_ex_s;
  logic       hit_wb_s;
  logic       need_ex_s;
  logic       need_wb_s;
  logic       stall_s;

  assign ex_a_s   = id_valid && ex_WriteReg && (ex_rd == id_rs1);
  assign ex_b_s   = id_valid && ex_WriteReg && id_uses_rs2 && (ex_rd == id_rs2);
  assign hit_ex_s = ex_a_s || ex_b_s;
  assign hit_wb_s = id_valid && wb_WriteReg &&
                    ((wb_rd == id_rs1) || (id_uses_rs2 && (wb_rd == id_rs2)));

  // With forwarding the EX producer is bypassed, so only the WB case stalls.
  assign need_ex_s = hit_ex_s && !FWD_EN;
  assign need_wb_s = hit_wb_s;
  assign stall_s   = (state_r != ST_RUN) || need_ex_s || need_wb_s;

  // Pipeline enables: reset, then branch flush, then stall, then normal flow.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
    end else if (branch_taken) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall_s) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
    end
  end

  // Operand selects for the instruction about to enter EX.
  always_comb begin
    fwd_a_s = FWD_RF;
    fwd_b_s = FWD_RF;
    if (FWD_EN && ex_a_s) begin
      fwd_a_s = fwd_src(ex_SEtoReg);
    end else begin
      fwd_a_s = FWD_RF;
    end
    if (FWD_EN && ex_b_s) begin
      fwd_b_s = fwd_src(ex_SEtoReg);
    end else begin
      fwd_b_s = FWD_RF;
    end
  end

  // Stall sequencer; a taken branch abandons any stall in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else if (branch_taken) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (need_ex_s) begin
            state_r <= ST_STALL2;
          end else if (need_wb_s) begin
            state_r <= ST_STALL1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_STALL2: state_r <= ST_STALL1;
        ST_STALL1: state_r <= ST_RUN;
        default:   state_r <= ST_RUN;
      endcase
    end
  end

  // Selects only follow a real instruction into EX; a bubble reads the regfile.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a_r <= FWD_RF;
      fwd_b_r <= FWD_RF;
    end else if (idex_bubble) begin
      fwd_a_r <= FWD_RF;
      fwd_b_r <= FWD_RF;
    end else begin
      fwd_a_r <= fwd_a_s;
      fwd_b_r <= fwd_b_s;
    end
  end

  assign fwd_a = fwd_a_r;
  assign fwd_b = fwd_b_r;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_write),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (branch_taken),
    .clr   (cnt_clr),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl; expectations follow the
// build configuration (HAZARD_FORWARDING_EN defined or not).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [2:0] id_rs1;
  logic [2:0] id_rs2;
  logic       id_uses_rs2;
  logic       ex_WriteReg;
  logic       ex_SEtoReg;
  logic [2:0] ex_rd;
  logic       wb_WriteReg;
  logic [2:0] wb_rd;
  logic       branch_taken;
  logic       cnt_clr;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [7:0] stall_cnt;
  logic [7:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs2  (id_uses_rs2),
    .ex_WriteReg  (ex_WriteReg),
    .ex_SEtoReg   (ex_SEtoReg),
    .ex_rd        (ex_rd),
    .wb_WriteReg  (wb_WriteReg),
    .wb_rd        (wb_rd),
    .branch_taken (branch_taken),
    .cnt_clr      (cnt_clr),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       u2;
    logic       exw;
    logic       se;
    logic [2:0] exrd;
    logic       wbw;
    logic [2:0] wbrd;
    logic       br;
    logic       clr;
    logic [3:0] comb;  // {pc_write, ifid_write, ifid_flush, idex_bubble}
    logic [1:0] fa;
    logic [1:0] fb;
    logic [7:0] sc;
    logic [7:0] fc;
  } vec_t;

  localparam logic [3:0] RUNC   = 4'b1100;
  localparam logic [3:0] STALLC = 4'b0001;
  localparam logic [3:0] FLUSHC = 4'b1111;
  localparam logic [3:0] RSTC   = 4'b0001;

  vec_t vecs[$];

  function automatic vec_t mk(int rst, int v, int rs1, int rs2, int u2, int exw,
                              int se, int exrd, int wbw, int wbrd, int br, int clr,
                              logic [3:0] comb, int fa, int fb, int sc, int fc);
    vec_t t;
    t.rst = rst[0];  t.v = v[0];  t.rs1 = rs1[2:0];  t.rs2 = rs2[2:0];
    t.u2 = u2[0];  t.exw = exw[0];  t.se = se[0];  t.exrd = exrd[2:0];
    t.wbw = wbw[0];  t.wbrd = wbrd[2:0];  t.br = br[0];  t.clr = clr[0];
    t.comb = comb;  t.fa = fa[1:0];  t.fb = fb[1:0];
    t.sc = sc[7:0];  t.fc = fc[7:0];
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    reset = t.rst;  id_valid = t.v;  id_rs1 = t.rs1;  id_rs2 = t.rs2;
    id_uses_rs2 = t.u2;  ex_WriteReg = t.exw;  ex_SEtoReg = t.se;
    ex_rd = t.exrd;  wb_WriteReg = t.wbw;  wb_rd = t.wbrd;
    branch_taken = t.br;  cnt_clr = t.clr;
  endtask

  task automatic apply(input int idx, input vec_t t);
    @(negedge clk);
    drive(t);
    #1;
    chk("pc_write",    idx, {31'd0, pc_write},    {31'd0, t.comb[3]});
    chk("ifid_write",  idx, {31'd0, ifid_write},  {31'd0, t.comb[2]});
    chk("ifid_flush",  idx, {31'd0, ifid_flush},  {31'd0, t.comb[1]});
    chk("idex_bubble", idx, {31'd0, idex_bubble}, {31'd0, t.comb[0]});
    @(posedge clk);
    #1;
    chk("fwd_a",     idx, {30'd0, fwd_a},     {30'd0, t.fa});
    chk("fwd_b",     idx, {30'd0, fwd_b},     {30'd0, t.fb});
    chk("stall_cnt", idx, {24'd0, stall_cnt}, {24'd0, t.sc});
    chk("flush_cnt", idx, {24'd0, flush_cnt}, {24'd0, t.fc});
  endtask

  int no_stall;

  initial begin
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0, RSTC,0,0,0,0));

    // Reset, idle, WB hazard, non-matches, register 0, branch during STALL1
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, RSTC,0,0,0,0));
    vecs.push_back(mk(1,1,3,0,0,1,0,3,0,0,1,0, RSTC,0,0,0,0));
    vecs.push_back(mk(0,1,1,2,1,0,0,0,0,0,0,0, RUNC,0,0,0,0));
    vecs.push_back(mk(0,1,5,2,1,0,0,0,1,5,0,0, STALLC,0,0,1,0));
    vecs.push_back(mk(0,1,5,2,1,0,0,0,0,0,0,0, STALLC,0,0,2,0));
    vecs.push_back(mk(0,1,5,2,1,0,0,0,0,0,0,0, RUNC,0,0,2,0));
    vecs.push_back(mk(0,1,1,4,0,1,0,4,0,0,0,0, RUNC,0,0,2,0));
    vecs.push_back(mk(0,0,1,2,1,0,0,0,1,1,0,0, RUNC,0,0,2,0));
    vecs.push_back(mk(0,1,0,0,1,0,0,0,1,0,0,0, STALLC,0,0,3,0));
    vecs.push_back(mk(0,1,0,0,1,0,0,0,0,0,1,0, FLUSHC,0,0,3,1));
    vecs.push_back(mk(0,1,1,2,1,0,0,0,0,0,0,0, RUNC,0,0,3,1));
`ifdef HAZARD_FORWARDING_EN
    vecs.push_back(mk(0,1,3,2,1,1,0,3,0,0,0,0, RUNC,1,0,3,1));
    vecs.push_back(mk(0,1,1,3,1,1,1,3,0,0,0,0, RUNC,0,2,3,1));
    vecs.push_back(mk(0,1,1,3,1,1,0,3,0,0,0,0, RUNC,0,1,3,1));
    vecs.push_back(mk(0,1,4,4,1,1,1,4,0,0,0,0, RUNC,2,2,3,1));
    vecs.push_back(mk(0,1,1,4,0,1,1,4,0,0,0,0, RUNC,0,0,3,1));
    vecs.push_back(mk(0,1,1,2,1,1,0,1,1,2,0,0, STALLC,0,0,4,1));
    vecs.push_back(mk(0,1,1,2,1,1,0,1,0,0,0,0, STALLC,0,0,5,1));
    vecs.push_back(mk(0,1,1,2,1,1,0,1,0,0,0,0, RUNC,1,0,5,1));
    vecs.push_back(mk(0,1,1,2,1,1,0,1,0,0,1,0, FLUSHC,0,0,5,2));
    vecs.push_back(mk(0,1,1,2,1,0,0,0,0,0,0,0, RUNC,0,0,5,2));
    vecs.push_back(mk(0,1,3,2,1,1,1,3,0,0,0,0, RUNC,2,0,5,2));
    vecs.push_back(mk(1,1,3,2,1,1,1,3,0,0,0,0, RSTC,0,0,0,0));
    vecs.push_back(mk(0,1,3,2,1,0,0,0,0,0,0,0, RUNC,0,0,0,0));
`else
    vecs.push_back(mk(0,1,3,2,1,1,0,3,0,0,0,0, STALLC,0,0,4,1));
    vecs.push_back(mk(0,1,3,2,1,0,0,0,0,0,0,0, STALLC,0,0,5,1));
    vecs.push_back(mk(0,1,3,2,1,0,0,0,0,0,0,0, STALLC,0,0,6,1));
    vecs.push_back(mk(0,1,3,2,1,0,0,0,0,0,0,0, RUNC,0,0,6,1));
    vecs.push_back(mk(0,1,1,6,1,1,1,6,0,0,0,0, STALLC,0,0,7,1));
    vecs.push_back(mk(0,1,1,6,1,0,0,0,0,0,1,0, FLUSHC,0,0,7,2));
    vecs.push_back(mk(0,1,1,6,1,0,0,0,0,0,0,0, RUNC,0,0,7,2));
    vecs.push_back(mk(0,1,1,2,1,1,0,1,1,2,0,0, STALLC,0,0,8,2));
    vecs.push_back(mk(0,1,1,2,1,0,0,0,0,0,0,0, STALLC,0,0,9,2));
    vecs.push_back(mk(0,1,1,2,1,0,0,0,0,0,0,0, STALLC,0,0,10,2));
    vecs.push_back(mk(0,1,1,2,1,0,0,0,0,0,0,0, RUNC,0,0,10,2));
    vecs.push_back(mk(0,1,3,2,1,1,0,3,0,0,0,0, STALLC,0,0,11,2));
    vecs.push_back(mk(1,1,3,2,1,0,0,0,0,0,0,0, RSTC,0,0,0,0));
    vecs.push_back(mk(0,1,3,2,1,0,0,0,0,0,0,0, RUNC,0,0,0,0));
`endif

    foreach (vecs[i]) apply(i, vecs[i]);

    // Three taken branches, then a WB hazard held so every cycle stalls.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(mk(0,1,1,2,1,0,0,0,0,0,1,0, FLUSHC,0,0,0,0));
    end
    @(posedge clk);
    #1;
    chk("flush_cnt_3", 0, {24'd0, flush_cnt}, 32'd3);

    no_stall = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(mk(0,1,5,2,1,0,0,0,1,5,0,0, STALLC,0,0,0,0));
      #1;
      if (pc_write !== 1'b0) no_stall++;
    end
    chk("held_stall", 0, no_stall, 32'd0);
    @(posedge clk);
    #1;
    chk("stall_cnt_sat", 0, {24'd0, stall_cnt}, 32'd255);
    chk("flush_cnt_hold", 0, {24'd0, flush_cnt}, 32'd3);

    @(negedge clk);
    drive(mk(0,1,5,2,1,0,0,0,1,5,0,1, STALLC,0,0,0,0));
    #1;
    chk("clr_cycle_stall", 0, {31'd0, pc_write}, 32'd0);
    @(posedge clk);
    #1;
    chk("stall_cnt_clr", 0, {24'd0, stall_cnt}, 32'd0);
    chk("flush_cnt_clr", 0, {24'd0, flush_cnt}, 32'd0);

    @(negedge clk);
    drive(mk(0,1,5,2,1,0,0,0,1,5,0,0, STALLC,0,0,0,0));
    @(posedge clk);
    #1;
    chk("stall_cnt_after_clr", 0, {24'd0, stall_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
